xcvr_reset_seq: RTL and testbench

// Power-up and recovery reset sequencer for the SFP+ PHY clocking chain. Runs on the free-running
// 25 MHz reference after its BUFG. Drives the MMCM RST and the transceiver control reset
// (xcvr_ctrl_rst of the PHY wrapper). Watches MMCM lock and QPLL0 lock, re-sequences on timeout or

---
 rtl/xcvr_reset_seq.sv | 165 ++++++++++++++++
 tb/tb_xcvr_reset_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_reset_seq.sv
// Power-up / recovery reset sequencer for the SFP+ PHY clocking chain (MMCM, then transceiver).
// Latency: lock input edge to state change is SYNC_STAGES+1 cycles; outputs are Moore (state register only).
// Backpressure: none; free-running sequencer that re-sequences on lock timeout or lock loss.
module xcvr_reset_seq #(
  parameter int unsigned MMCM_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 25000,
  parameter int unsigned STABLE_CYCLES   = 256,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       qpll0lock,
  output logic       mmcm_rst,
  output logic       xcvr_ctrl_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_count
);

  // Encoded values are visible on the state port, so they are fixed here.
  typedef enum logic [2:0] {
    RESET_MMCM = 3'd0,
    WAIT_MMCM  = 3'd1,
    HOLD_XCVR  = 3'd2,
    WAIT_QPLL  = 3'd3,
    RUN        = 3'd4
  } state_e;

  // Terminal counts: each phase ends on the cycle its counter reaches these.
  localparam logic [CNT_W-1:0] MMCM_TERM    = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TERM  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [7:0]       RETRY_MAX    = 8'hFF;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             retry_q, retry_d;
  logic                   retry_inc;
  logic [SYNC_STAGES-1:0] mmcm_sync_q;
  logic [SYNC_STAGES-1:0] qpll_sync_q;
  logic                   mmcm_s;
  logic                   qpll_s;

  // Both lock inputs come from other clock domains; bring them in through plain flop chains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmcm_sync_q <= '0;
      qpll_sync_q <= '0;
    end else begin
      mmcm_sync_q <= {mmcm_sync_q[SYNC_STAGES-2:0], mmcm_locked};
      qpll_sync_q <= {qpll_sync_q[SYNC_STAGES-2:0], qpll0lock};
    end
  end

  assign mmcm_s = mmcm_sync_q[SYNC_STAGES-1];
  assign qpll_s = qpll_sync_q[SYNC_STAGES-1];

  // Next-state and counter logic. MMCM lock loss is checked first in every state so that it
  // wins over QPLL loss or timeout, which in turn win over normal progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_inc = 1'b0;

    case (state_q)
      RESET_MMCM: begin
        if (cnt_q == MMCM_TERM) begin
          state_d = WAIT_MMCM;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_MMCM: begin
        if (mmcm_s) begin
          state_d = HOLD_XCVR;
        end else if (cnt_q == TIMEOUT_TERM) begin
          state_d   = RESET_MMCM;
          retry_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD_XCVR: begin
        if (!mmcm_s) begin
          state_d   = RESET_MMCM;
          retry_inc = 1'b1;
        end else if (cnt_q == STABLE_TERM) begin
          state_d = WAIT_QPLL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_QPLL: begin
        if (!mmcm_s) begin
          state_d   = RESET_MMCM;
          retry_inc = 1'b1;
        end else if (qpll_s) begin
          state_d = RUN;
        end else if (cnt_q == TIMEOUT_TERM) begin
          // QPLL timeout only re-holds the transceiver; the MMCM is still good.
          state_d   = HOLD_XCVR;
          retry_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RUN: begin
        // No timing in RUN; the counter simply rests at zero.
        if (!mmcm_s) begin
          state_d   = RESET_MMCM;
          retry_inc = 1'b1;
        end else if (!qpll_s) begin
          state_d   = HOLD_XCVR;
          retry_inc = 1'b1;
        end
      end

      default: begin
        // Unused encodings recover straight to the start without counting as a retry.
        state_d = RESET_MMCM;
      end
    endcase

    // Every phase starts timing from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Retry counter saturates so a long-dead PLL never looks freshly reset.
  always_comb begin
    retry_d = retry_q;
    if (retry_inc && (retry_q != RETRY_MAX)) begin
      retry_d = retry_q + 8'd1;
    end
  end

  // State, counter and retry registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_MMCM;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Moore outputs decoded from the state register only.
  assign mmcm_rst      = (state_q == RESET_MMCM);
  assign xcvr_ctrl_rst = (state_q != WAIT_QPLL) && (state_q != RUN);
  assign ready         = (state_q == RUN);
  assign state         = state_q;
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_xcvr_reset_seq.sv
// Bench for xcvr_reset_seq: directed bring-up/failure scenarios plus random lock activity.
// Expected outputs come from a phase/elapsed-time reference model and flow through a queue.
// A negedge monitor pops one expectation per cycle and compares it against the DUT outputs.
module tb_xcvr_reset_seq;

  localparam int MRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  localparam int SYN = 2;

  logic       clk;
  logic       rst_n;
  logic       mmcm_locked;
  logic       qpll0lock;
  logic       mmcm_rst;
  logic       xcvr_ctrl_rst;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_count;

  xcvr_reset_seq #(
    .MMCM_RST_CYCLES(MRC),
    .LOCK_TIMEOUT   (LTO),
    .STABLE_CYCLES  (STC),
    .SYNC_STAGES    (SYN),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mmcm_locked  (mmcm_locked),
    .qpll0lock    (qpll0lock),
    .mmcm_rst     (mmcm_rst),
    .xcvr_ctrl_rst(xcvr_ctrl_rst),
    .ready        (ready),
    .state        (state),
    .retry_count  (retry_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int phase;
    bit mrst;
    bit xrst;
    bit rdy;
    int retries;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string name, input int act, input int req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in it, retries, and a delay line standing in
  // for the input synchronizers.
  int m_phase = 0;
  int m_t     = 0;
  int m_retry = 0;
  bit m_dly[$];
  bit q_dly[$];

  function automatic void bump_retry();
    if (m_retry < 255) m_retry++;
  endfunction

  function automatic void enter(input int p);
    m_phase = p;
    m_t     = 0;
  endfunction

  function automatic void model_step(input bit r, input bit m, input bit q);
    bit ms;
    bit qs;
    if (!r) begin
      m_phase = 0;
      m_t     = 0;
      m_retry = 0;
      m_dly   = {};
      q_dly   = {};
      for (int i = 0; i < SYN; i++) begin
        m_dly.push_back(1'b0);
        q_dly.push_back(1'b0);
      end
      return;
    end
    ms = m_dly.pop_front();
    qs = q_dly.pop_front();
    m_dly.push_back(m);
    q_dly.push_back(q);
    // Elapsed cycles in the phase after this edge if nothing happens.
    if (m_phase == 0) begin
      if (m_t + 1 >= MRC) enter(1); else m_t++;
    end else if (m_phase == 1) begin
      if (ms) enter(2);
      else if (m_t + 1 >= LTO) begin enter(0); bump_retry(); end
      else m_t++;
    end else if (m_phase == 2) begin
      if (!ms) begin enter(0); bump_retry(); end
      else if (m_t + 1 >= STC) enter(3);
      else m_t++;
    end else if (m_phase == 3) begin
      if (!ms) begin enter(0); bump_retry(); end
      else if (qs) enter(4);
      else if (m_t + 1 >= LTO) begin enter(2); bump_retry(); end
      else m_t++;
    end else begin
      if (!ms) begin enter(0); bump_retry(); end
      else if (!qs) begin enter(2); bump_retry(); end
    end
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model and queue its expectation.
  task automatic tick(input bit r, input bit m, input bit q);
    exp_t e;
    rst_n       = r;
    mmcm_locked = m;
    qpll0lock   = q;
    @(posedge clk);
    model_step(r, m, q);
    e.phase   = m_phase;
    e.mrst    = (m_phase == 0);
    e.xrst    = !(m_phase == 3 || m_phase == 4);
    e.rdy     = (m_phase == 4);
    e.retries = m_retry;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: the sequencer presents a new output every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_state", int'(state), e.phase);
      chk("sb_mmcm_rst", int'(mmcm_rst), int'(e.mrst));
      chk("sb_xcvr_ctrl_rst", int'(xcvr_ctrl_rst), int'(e.xrst));
      chk("sb_ready", int'(ready), int'(e.rdy));
      chk("sb_retry_count", int'(retry_count), e.retries);
    end
  end

  initial begin
    int mrst_cnt;
    int hold_cnt;
    int fell_at;
    int xlow_cnt;
    int found;
    bit ml;
    bit ql;

    rst_n       = 1'b0;
    mmcm_locked = 1'b0;
    qpll0lock   = 1'b0;
    for (int i = 0; i < SYN; i++) begin
      m_dly.push_back(1'b0);
      q_dly.push_back(1'b0);
    end

    // Normal bring-up.
    repeat (3) tick(0, 0, 0);
    #4;
    chk("rst_state", int'(state), 0);
    chk("rst_mmcm_rst", int'(mmcm_rst), 1);
    chk("rst_xcvr_ctrl_rst", int'(xcvr_ctrl_rst), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_retry", int'(retry_count), 0);
    mrst_cnt = 0;
    hold_cnt = 0;
    fell_at  = -1;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) #4;
      if (mmcm_rst) mrst_cnt++;
      if (state == 3'd2) hold_cnt++;
      if (fell_at < 0 && !xcvr_ctrl_rst) fell_at = i;
      ml = (i >= 10);
      ql = (fell_at >= 0) && (i >= fell_at + 5);
      tick(1, ml, ql);
    end
    #4;
    chk("up_mmcm_rst_cycles", mrst_cnt, MRC);
    chk("up_hold_cycles", hold_cnt, STC);
    chk("up_state", int'(state), 4);
    chk("up_ready", int'(ready), 1);
    chk("up_retry", int'(retry_count), 0);
    chk("up_xcvr_ctrl_rst", int'(xcvr_ctrl_rst), 0);

    // MMCM never locks: long enough to saturate the retry counter.
    repeat (2) tick(0, 0, 0);
    xlow_cnt = 0;
    for (int i = 0; i < 7000; i++) begin
      tick(1, 0, 0);
      #4;
      if (!xcvr_ctrl_rst) xlow_cnt++;
      if (i == 4 * 24 + 3) chk("nolock_retry_early", int'(retry_count), 4);
    end
    chk("nolock_xcvr_low_cycles", xlow_cnt, 0);
    chk("nolock_retry_sat", int'(retry_count), 255);

    // MMCM locks, QPLL never does.
    repeat (2) tick(0, 0, 0);
    mrst_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1, 1, 0);
      #4;
      if (i >= 20 && mmcm_rst) mrst_cnt++;
    end
    chk("noqpll_mmcm_rst_cycles", mrst_cnt, 0);

    // Simultaneous loss of both locks in RUN: MMCM loss must win.
    repeat (2) tick(0, 0, 0);
    repeat (40) tick(1, 1, 1);
    #4;
    chk("drop_pre_state", int'(state), 4);
    tick(1, 0, 0);
    tick(1, 0, 0);
    #4;
    chk("drop_2cyc_state", int'(state), 4);
    tick(1, 0, 0);
    #4;
    chk("drop_3cyc_state", int'(state), 0);
    chk("drop_3cyc_ready", int'(ready), 0);
    chk("drop_3cyc_retry", int'(retry_count), 1);
    repeat (10) tick(1, 0, 0);

    // One-cycle reset while waiting for QPLL after three retries.
    repeat (2) tick(0, 0, 0);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick(1, 1, 0);
      #4;
      if (state == 3'd3 && retry_count == 8'd3) found = 1;
    end
    chk("midrst_reached_wait_qpll", found, 1);
    tick(0, 1, 0);
    #4;
    chk("midrst_state", int'(state), 0);
    chk("midrst_mmcm_rst", int'(mmcm_rst), 1);
    chk("midrst_xcvr_ctrl_rst", int'(xcvr_ctrl_rst), 1);
    chk("midrst_retry", int'(retry_count), 0);

    // Random lock activity with occasional resets.
    ml = 1'b0;
    ql = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 3) ml = ~ml;
      if ($urandom_range(99) < 6) ql = ~ql;
      tick(($urandom_range(499) != 0), ml, ql);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
